crc_code_encoder: RTL and testbench
===================================

Name: crc_code_encoder

Overview:
Serial CRC-4 encoder, the write-side counterpart of the CRC decoder on the memory-protection path. Accepts an 8-bit data word over a valid/ready handshake and computes the CRC MSB-first through a 4-bit Galois LFSR, one data bit per clock. Presents the 12-bit codeword {data, crc} with a valid/ready handshake. Its codewords must check clean, with remainder 0, in the matching serial CRC decoder.

Parameters:
DATA_WIDTH, 8, data bits per word.
CRC_WIDTH, 4, check bits and LFSR width.
POLY, 4'h3, generator polynomial without the x^4 term. Default is x^4+x+1.

Ports:
clk  in  1  single clock; all state changes on the rising edge.
rst  in  1  reset, asynchronous and active-low. Asserted (0) forces all state to reset values immediately.
clear  in  1  synchronous abort; returns the block to IDLE and discards any word in flight.
in_data  in  DATA_WIDTH  word to encode.
in_valid  in  1  in_data is valid.
in_ready  out  1  encoder can accept a word.
out_data  out  DATA_WIDTH+CRC_WIDTH  codeword. Bits [11:4] are data, bits [3:0] are CRC.
out_valid  out  1  out_data holds a complete codeword.
out_ready  in  1  downstream consumes the codeword.
busy  out  1  high in SHIFT or DONE.

Behaviour:
- FSM states: IDLE, SHIFT, DONE.
- Reset values: state=IDLE, lfsr=0, shift register=0, data register=0, bit counter=0, out_data=0, out_valid=0, busy=0, in_ready=1.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. busy=1 in SHIFT or DONE.
- IDLE: when in_valid and in_ready are both high at an edge:
  - data register and shift register load in_data;
  - lfsr clears to 0 and counter clears to 0;
  - state goes to SHIFT.
- SHIFT, each edge:
  - din = shift_reg[MSB] and fb = lfsr[3]^din;
  - lfsr <= {lfsr[2:0],1'b0} ^ (fb ? POLY : 0); with the default this is {lfsr[2], lfsr[1], lfsr[0]^fb, fb};
  - shift_reg shifts left, zero fill;
  - counter increments.
  - After the DATA_WIDTH-th shift (counter wraps from 7), state goes to DONE.
- DONE:
  - out_data = {data_reg, lfsr}, held stable while out_valid=1 and out_ready=0;
  - on out_ready=1, state returns to IDLE and out_valid drops the next cycle.
- Latency: out_valid rises exactly DATA_WIDTH (8) edges after the accepting edge. The next word can be accepted no earlier than the edge after the out_ready handshake. Minimum period is 10 cycles per word.
- Inputs are ignored outside IDLE: in_valid and in_data changes do not disturb a word in flight. out_ready is ignored outside DONE.
- CRC definition: remainder of data·x^4 mod g(x), MSB-first, LFSR initialised to 0, no final XOR.
- clear=1 at an edge from any state:
  - state goes to IDLE and lfsr and counter go to 0;
  - clear has priority over a simultaneous input handshake, so no word is accepted;
  - clear has priority over a simultaneous output handshake;
  - out_data keeps its last value, but out_valid=0.
- rst asserted mid-SHIFT or mid-DONE aborts the word. All outputs take their reset values asynchronously. After release the block is in IDLE with in_ready=1.
- out_data register updates only on entry to DONE. Between words it keeps the last codeword.

Test Plan:
1. Reset, then in_data=8'h01 -> out_valid rises 8 edges after accept; out_data=12'h013.
2. in_data=8'h80 -> 12'h80E. in_data=8'hFF -> 12'hFF4. in_data=8'h00 -> 12'h000.
3. Backpressure: hold out_ready=0 for 5 cycles with 8'h80. Check out_data stays at 12'h80E, out_valid stays 1, and in_ready=0 throughout. Change in_data/in_valid during SHIFT and confirm the result is unaffected.
4. Back-to-back: in_valid held high with 8'h01 then 8'hFF, out_ready=1. Expect 12'h013 then 12'hFF4, with acceptances exactly 10 cycles apart.
5. Abort:
   - clear at the 4th shift edge: check IDLE and in_ready=1 next cycle, no out_valid, and a following 8'h80 encodes to 12'h80E;
   - repeat with rst dropped mid-SHIFT: outputs go to reset values immediately.
6. Loopback: for random 1000 words, feed each out_data into the serial CRC decoder. Expect error_detected=0 for clean codewords. Flip any single codeword bit and expect error_detected=1.

Source files
------------

// File: rtl/crc_code_encoder.sv
// crc_code_encoder: serial MSB-first CRC encoder producing {data, crc} codewords over valid/ready
module crc_code_encoder #(
    parameter int                       DATA_WIDTH = 8,
    parameter int                       CRC_WIDTH  = 4,
    parameter logic [CRC_WIDTH-1:0]     POLY       = 'h3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH+CRC_WIDTH-1:0]  out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                            state_q, state_d;
    logic [CRC_WIDTH-1:0]              lfsr_q, lfsr_d, lfsr_step;
    logic [DATA_WIDTH-1:0]             shift_q, shift_d;
    logic [DATA_WIDTH-1:0]             data_q, data_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [DATA_WIDTH+CRC_WIDTH-1:0]   out_q, out_d;
    logic                              fb;

    assign fb        = lfsr_q[CRC_WIDTH-1] ^ shift_q[DATA_WIDTH-1];
    assign lfsr_step = {lfsr_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;

    // State and datapath registers; reset drops everything to idle immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Next state: clear wins over both handshakes; codeword latched only on entry to DONE
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        shift_d = shift_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (clear) begin
            state_d = IDLE;
            lfsr_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    data_d  = in_data;
                    shift_d = in_data;
                    lfsr_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    lfsr_d  = lfsr_step;
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_d = DONE;
                        out_d   = {data_q, lfsr_step};
                    end
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_code_encoder.sv
// tb_crc_code_encoder: randomized self-checking bench with a polynomial-division reference model
module tb_crc_code_encoder;
    logic        clk = 1'b0, rst = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_ready, out_valid, busy;
    logic [11:0] out_data;

    int          errors = 0, checks = 0;
    int          cyc = 0, acc_cyc = 0, acc_cnt = 0, m_st = 0;
    logic [7:0]  m_word = '0;
    logic [11:0] m_out = '0;
    int          acc_hist[$];
    logic [11:0] cap_q[$];
    logic        prev_valid = 1'b0;

    crc_code_encoder dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Remainder of a 12-bit polynomial modulo x^4+x+1 by long division
    function automatic logic [3:0] rem12(input logic [11:0] cw);
        logic [11:0] r;
        r = cw;
        for (int i = 11; i >= 4; i--)
            if (r[i]) r = r ^ (12'h13 << (i - 4));
        return r[3:0];
    endfunction

    function automatic logic [3:0] crc_of(input logic [7:0] d);
        return rem12({d, 4'h0});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: 0 idle, 1..8 shifting, 9 codeword presented
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st  <= 0;
            m_out <= '0;
        end else begin
            cyc <= cyc + 1;
            if (clear) m_st <= 0;
            else if (m_st == 0 && in_valid) begin
                m_st    <= 1;
                m_word  <= in_data;
                acc_cyc <= cyc + 1;
                acc_cnt <= acc_cnt + 1;
                acc_hist.push_back(cyc + 1);
            end else if (m_st >= 1 && m_st <= 8) begin
                m_st <= m_st + 1;
                if (m_st == 8) m_out <= {m_word, crc_of(m_word)};
            end else if (m_st == 9 && out_ready) m_st <= 0;
        end
    end

    // Per-cycle compare and codeword capture, away from the active edge
    always @(negedge clk) begin
        #1;
        chk("in_ready", in_ready, m_st == 0);
        chk("out_valid", out_valid, m_st == 9);
        chk("busy", busy, m_st != 0);
        chk("out_data", out_data, m_out);
        if (out_valid && !prev_valid) chk("latency", cyc - acc_cyc, 8);
        if (out_valid && out_ready && !clear && rst) cap_q.push_back(out_data);
        prev_valid = out_valid;
    end

    task automatic send(input logic [7:0] d);
        int n0;
        n0 = acc_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 40 && acc_cnt == n0; i++) @(negedge clk);
        in_valid = 1'b0;
        if (acc_cnt == n0) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_word(output logic [11:0] cw);
        cw = '0;
        for (int i = 0; i < 60 && cap_q.size() == 0; i++) @(negedge clk);
        if (cap_q.size() == 0) chk("word_timeout", 0, 1);
        else cw = cap_q.pop_front();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        #1;
        chk("valid_wait", out_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] cw;
        logic [7:0]  d;
        int          n0, b;
        chk("model_crc_01", crc_of(8'h01), 4'h3);
        chk("model_crc_80", crc_of(8'h80), 4'hE);
        chk("model_crc_FF", crc_of(8'hFF), 4'h4);
        chk("model_crc_00", crc_of(8'h00), 4'h0);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        #1 rst = 1'b1;

        send(8'h01); wait_word(cw); chk("w01", cw, 12'h013);
        send(8'h80); wait_word(cw); chk("w80", cw, 12'h80E);
        send(8'hFF); wait_word(cw); chk("wFF", cw, 12'hFF4);
        send(8'h00); wait_word(cw); chk("w00", cw, 12'h000);

        out_ready = 1'b0;
        send(8'h80);
        repeat (3) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("bp_data", out_data, 12'h80E);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        wait_word(cw); chk("bp_word", cw, 12'h80E);

        cap_q.delete();
        @(negedge clk);
        n0 = acc_cnt;
        in_valid = 1'b1;
        in_data  = 8'h01;
        for (int i = 0; i < 40 && acc_cnt == n0; i++) @(negedge clk);
        in_data = 8'hFF;
        for (int i = 0; i < 40 && acc_cnt < n0 + 2; i++) @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_accepts", acc_cnt - n0, 2);
        if (acc_hist.size() >= 2) chk("b2b_gap", acc_hist[$] - acc_hist[$-1], 10);
        wait_word(cw); chk("b2b_w0", cw, 12'h013);
        wait_word(cw); chk("b2b_w1", cw, 12'hFF4);

        send(8'h55);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr_in_ready", in_ready, 1);
        chk("clr_busy", busy, 0);
        chk("clr_valid", out_valid, 0);
        n0 = acc_cnt;
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'h33;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        #1;
        chk("clr_no_accept", busy, 0);
        chk("clr_acc_cnt", acc_cnt - n0, 0);
        send(8'h80); wait_word(cw); chk("clr_w80", cw, 12'h80E);

        out_ready = 1'b0;
        send(8'h01);
        wait_valid();
        @(negedge clk);
        clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr_done_valid", out_valid, 0);
        chk("clr_done_data", out_data, 12'h013);
        chk("clr_done_nocap", cap_q.size(), 0);

        send(8'hA5);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        send(8'h80); wait_word(cw); chk("arst_w80", cw, 12'h80E);

        cap_q.delete();
        for (int k = 0; k < 1000; k++) begin
            d = 8'($urandom);
            send(d);
            wait_word(cw);
            b = $urandom_range(0, 11);
            chk("lb_data", cw[11:4], d);
            chk("lb_clean", rem12(cw), 0);
            chk("lb_flip", rem12(cw ^ (12'h001 << b)) != 4'h0, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
